// File: rtl/mm_tile_ctrl.sv
// mm_tile_ctrl
//   Tile-sequencing controller for the matrix-multiply accelerator. Walks the
//   output matrix in TILE x TILE tiles (row batches outer, column tiles inner).
//   For every tile it feeds A/B operands into the systolic array, waits for the
//   array to drain, then writes the valid result rows to buffer P.
//
//   Control flow: IDLE -> FEED -> DRAIN -> WRITE -> (FEED ... | DONE) -> IDLE.
//   All buffer-facing outputs come from an output register stage loaded from
//   the decode of the current state, so they lag the state by one cycle.
//   stall_i freezes every register, including that output stage, and masks
//   the enables combinationally. The cycle visible when the stall rises is
//   therefore re-issued unchanged once the stall drops.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                level start request, sampled in IDLE
//   stall_i                freeze everything this cycle, enables forced low
//   m_i, k_i, n_i          A is m x k, B is k x n (latched at start)
//   base_addr{a,b,p}_i     buffer base addresses (latched at start)
//   valid_o                high while DONE is presented
//   batch_begin_o/_end_o   first / last FEED cycle of a tile
//   ensys_o                systolic shift enable (FEED or DRAIN, not stalled)
//   bubble_o               FEED cycle beyond k, array inputs zeroed
//   ena_o/enb_o, addra_o/addrb_o   operand reads
//   enp_o/wep_o, addrp_o, row_sel_o result writes
`timescale 1ns/1ps
module mm_tile_ctrl #(
  parameter int ADDR_WIDTH   = 16,
  parameter int TILE         = 8,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    stall_i,
  input  logic [ADDR_WIDTH-1:0]   m_i,
  input  logic [ADDR_WIDTH-1:0]   k_i,
  input  logic [ADDR_WIDTH-1:0]   n_i,
  input  logic [ADDR_WIDTH-1:0]   base_addra_i,
  input  logic [ADDR_WIDTH-1:0]   base_addrb_i,
  input  logic [ADDR_WIDTH-1:0]   base_addrp_i,
  output logic                    valid_o,
  output logic                    batch_begin_o,
  output logic                    batch_end_o,
  output logic                    ensys_o,
  output logic                    bubble_o,
  output logic                    ena_o,
  output logic                    enb_o,
  output logic [ADDR_WIDTH-1:0]   addra_o,
  output logic [ADDR_WIDTH-1:0]   addrb_o,
  output logic                    enp_o,
  output logic                    wep_o,
  output logic [ADDR_WIDTH-1:0]   addrp_o,
  output logic [$clog2(TILE)-1:0] row_sel_o
);

  localparam int AW = ADDR_WIDTH;
  localparam int TW = $clog2(TILE);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  // ceil(x / TILE) with one extra bit so x = 2^AW-1 cannot overflow.
  function automatic logic [AW-1:0] ceil_tiles(input logic [AW-1:0] x);
    logic [AW:0] s;
    s = {1'b0, x} + (AW+1)'(TILE - 1);
    return AW'(s >> TW);
  endfunction

  state_t state_q, state_d;

  // Latched run parameters
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] base_b_q, base_b_d;
  logic [AW-1:0] rtiles_q, rtiles_d;
  logic [AW-1:0] ctiles_q, ctiles_d;
  logic [AW-1:0] f_last_q, f_last_d;

  // Counters
  logic [AW-1:0] f_q, f_d;
  logic [DW-1:0] d_q, d_d;
  logic [TW-1:0] row_q, row_d;
  logic [AW-1:0] rb_q, rb_d;
  logic [AW-1:0] cb_q, cb_d;
  logic [AW-1:0] m_rem_q, m_rem_d;

  // Running address bases, updated incrementally instead of multiplying:
  //   a_row  = base_a + rb*k
  //   b_col  = base_b + cb*k
  //   p_row  = base_p + rb*TILE*C
  //   p_tile = p_row + cb
  //   p_wr   = p_tile + r*C
  logic [AW-1:0] a_row_q, a_row_d;
  logic [AW-1:0] b_col_q, b_col_d;
  logic [AW-1:0] p_row_q, p_row_d;
  logic [AW-1:0] p_tile_q, p_tile_d;
  logic [AW-1:0] p_wr_q, p_wr_d;

  // Output register stage
  logic          valid_q, valid_d;
  logic          bb_q, bb_d;
  logic          be_q, be_d;
  logic          sys_q, sys_d;
  logic          bub_q, bub_d;
  logic          ena_q, ena_d;
  logic          enp_q, enp_d;
  logic [TW-1:0] rs_q, rs_d;
  logic [AW-1:0] addra_q, addra_d;
  logic [AW-1:0] addrb_q, addrb_d;
  logic [AW-1:0] addrp_q, addrp_d;

  logic          last_tile;
  logic          last_col;
  logic [TW-1:0] v_last;
  logic [AW-1:0] p_step;
  logic          feed_live;

  assign last_col  = (cb_q == ctiles_q - AW'(1));
  assign last_tile = last_col && (rb_q == rtiles_q - AW'(1));
  // Rows in the current batch minus one; only the last batch can be partial.
  assign v_last    = (m_rem_q >= AW'(TILE)) ? TW'(TILE - 1) : TW'(m_rem_q - AW'(1));
  assign p_step    = ctiles_q << TW;
  assign feed_live = (f_q < k_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else if (!stall_i) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    base_b_d = base_b_q;
    rtiles_d = rtiles_q;
    ctiles_d = ctiles_q;
    f_last_d = f_last_q;
    f_d      = f_q;
    d_d      = d_q;
    row_d    = row_q;
    rb_d     = rb_q;
    cb_d     = cb_q;
    m_rem_d  = m_rem_q;
    a_row_d  = a_row_q;
    b_col_d  = b_col_q;
    p_row_d  = p_row_q;
    p_tile_d = p_tile_q;
    p_wr_d   = p_wr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          k_d      = k_i;
          base_b_d = base_addrb_i;
          rtiles_d = ceil_tiles(m_i);
          ctiles_d = ceil_tiles(n_i);
          f_last_d = (k_i > AW'(TILE)) ? (k_i - AW'(1)) : AW'(TILE - 1);
          m_rem_d  = m_i;
          a_row_d  = base_addra_i;
          b_col_d  = base_addrb_i;
          p_row_d  = base_addrp_i;
          p_tile_d = base_addrp_i;
          f_d      = '0;
          d_d      = '0;
          row_d    = '0;
          rb_d     = '0;
          cb_d     = '0;
          if ((m_i == '0) || (k_i == '0) || (n_i == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FEED;
          end
        end
      end

      S_FEED: begin
        if (f_q == f_last_q) begin
          f_d     = '0;
          d_d     = '0;
          state_d = S_DRAIN;
        end else begin
          f_d = f_q + AW'(1);
        end
      end

      S_DRAIN: begin
        if (d_q == DW'(DRAIN_CYCLES - 1)) begin
          row_d   = '0;
          p_wr_d  = p_tile_q;
          state_d = S_WRITE;
        end else begin
          d_d = d_q + DW'(1);
        end
      end

      S_WRITE: begin
        if (row_q == v_last) begin
          if (last_tile) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FEED;
            f_d     = '0;
            if (last_col) begin
              cb_d     = '0;
              rb_d     = rb_q + AW'(1);
              b_col_d  = base_b_q;
              a_row_d  = a_row_q + k_q;
              p_row_d  = p_row_q + p_step;
              p_tile_d = p_row_q + p_step;
              m_rem_d  = m_rem_q - AW'(TILE);
            end else begin
              cb_d     = cb_q + AW'(1);
              b_col_d  = b_col_q + k_q;
              p_tile_d = p_tile_q + AW'(1);
            end
          end
        end else begin
          row_d  = row_q + TW'(1);
          p_wr_d = p_wr_q + ctiles_q;
        end
      end

      S_DONE: begin
        // Start held high after completion must not retrigger a run.
        if (!start_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the current state, registered below.
  always_comb begin
    valid_d = 1'b0;
    bb_d    = 1'b0;
    be_d    = 1'b0;
    sys_d   = 1'b0;
    bub_d   = 1'b0;
    ena_d   = 1'b0;
    enp_d   = 1'b0;
    rs_d    = '0;
    addra_d = '0;
    addrb_d = '0;
    addrp_d = '0;

    unique case (state_q)
      S_FEED: begin
        sys_d   = 1'b1;
        ena_d   = feed_live;
        bub_d   = !feed_live;
        bb_d    = (f_q == '0);
        be_d    = (f_q == f_last_q);
        addra_d = a_row_q + f_q;
        addrb_d = b_col_q + f_q;
      end
      S_DRAIN: begin
        sys_d = 1'b1;
      end
      S_WRITE: begin
        enp_d   = 1'b1;
        rs_d    = row_q;
        addrp_d = p_wr_q;
      end
      S_DONE: begin
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q      <= '0;
      base_b_q <= '0;
      rtiles_q <= '0;
      ctiles_q <= '0;
      f_last_q <= '0;
      f_q      <= '0;
      d_q      <= '0;
      row_q    <= '0;
      rb_q     <= '0;
      cb_q     <= '0;
      m_rem_q  <= '0;
      a_row_q  <= '0;
      b_col_q  <= '0;
      p_row_q  <= '0;
      p_tile_q <= '0;
      p_wr_q   <= '0;
      valid_q  <= 1'b0;
      bb_q     <= 1'b0;
      be_q     <= 1'b0;
      sys_q    <= 1'b0;
      bub_q    <= 1'b0;
      ena_q    <= 1'b0;
      enp_q    <= 1'b0;
      rs_q     <= '0;
      addra_q  <= '0;
      addrb_q  <= '0;
      addrp_q  <= '0;
    end else if (!stall_i) begin
      k_q      <= k_d;
      base_b_q <= base_b_d;
      rtiles_q <= rtiles_d;
      ctiles_q <= ctiles_d;
      f_last_q <= f_last_d;
      f_q      <= f_d;
      d_q      <= d_d;
      row_q    <= row_d;
      rb_q     <= rb_d;
      cb_q     <= cb_d;
      m_rem_q  <= m_rem_d;
      a_row_q  <= a_row_d;
      b_col_q  <= b_col_d;
      p_row_q  <= p_row_d;
      p_tile_q <= p_tile_d;
      p_wr_q   <= p_wr_d;
      valid_q  <= valid_d;
      bb_q     <= bb_d;
      be_q     <= be_d;
      sys_q    <= sys_d;
      bub_q    <= bub_d;
      ena_q    <= ena_d;
      enp_q    <= enp_d;
      rs_q     <= rs_d;
      addra_q  <= addra_d;
      addrb_q  <= addrb_d;
      addrp_q  <= addrp_d;
    end
  end

  // Enables are masked by the live stall; everything else just holds.
  assign valid_o       = valid_q;
  assign batch_begin_o = bb_q;
  assign batch_end_o   = be_q;
  assign bubble_o      = bub_q;
  assign ensys_o       = sys_q & ~stall_i;
  assign ena_o         = ena_q & ~stall_i;
  assign enb_o         = ena_q & ~stall_i;
  assign enp_o         = enp_q & ~stall_i;
  assign wep_o         = enp_q & ~stall_i;
  assign addra_o       = addra_q;
  assign addrb_o       = addrb_q;
  assign addrp_o       = addrp_q;
  assign row_sel_o     = rs_q;

endmodule

// File: tb/tb_mm_tile_ctrl.sv
`timescale 1ns/1ps
module tb_mm_tile_ctrl;

  localparam int AW    = 16;
  localparam int T     = 8;
  localparam int DRAIN = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [AW-1:0] m = '0, k = '0, n = '0, ba = '0, bb = '0, bp = '0;

  logic          valid_o, batch_begin_o, batch_end_o, ensys_o, bubble_o;
  logic          ena_o, enb_o, enp_o, wep_o;
  logic [AW-1:0] addra_o, addrb_o, addrp_o;
  logic [2:0]    row_sel_o;

  mm_tile_ctrl #(.ADDR_WIDTH(AW), .TILE(T), .DRAIN_CYCLES(DRAIN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stall_i(stall),
    .m_i(m), .k_i(k), .n_i(n),
    .base_addra_i(ba), .base_addrb_i(bb), .base_addrp_i(bp),
    .valid_o(valid_o), .batch_begin_o(batch_begin_o), .batch_end_o(batch_end_o),
    .ensys_o(ensys_o), .bubble_o(bubble_o), .ena_o(ena_o), .enb_o(enb_o),
    .addra_o(addra_o), .addrb_o(addrb_o), .enp_o(enp_o), .wep_o(wep_o),
    .addrp_o(addrp_o), .row_sel_o(row_sel_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        bb;
    logic        be;
    logic        sys;
    logic        bub;
    logic        ena;
    logic        enb;
    logic        enp;
    logic        wep;
    logic [2:0]  rs;
    logic [15:0] aa;
    logic [15:0] ab;
    logic [15:0] ap;
  } ent_t;

  ent_t dut_e;
  assign dut_e = {valid_o, batch_begin_o, batch_end_o, ensys_o, bubble_o,
                  ena_o, enb_o, enp_o, wep_o, row_sel_o, addra_o, addrb_o, addrp_o};

  ent_t        exp_q[$];
  ent_t        cmp_e;
  int          pos = 0;
  bit          chk_en = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          nbub, nena;
  logic [15:0] wq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Expected per-cycle output stream: one idle cycle (start being sampled),
  // then every FEED/DRAIN/WRITE cycle of every tile in row-batch-major order,
  // then one DONE cycle, then idle again.
  function automatic void build(input int mm, input int kk, input int nn,
                                input int a0, input int b0, input int p0);
    ent_t e;
    int   R, C, F, V;
    exp_q.delete();
    e = '0;
    exp_q.push_back(e);
    if (mm == 0 || kk == 0 || nn == 0) begin
      e = '0; e.valid = 1'b1; exp_q.push_back(e);
      e = '0; exp_q.push_back(e);
      return;
    end
    R = (mm + T - 1) / T;
    C = (nn + T - 1) / T;
    F = (kk > T) ? kk : T;
    for (int rb = 0; rb < R; rb++) begin
      for (int cb = 0; cb < C; cb++) begin
        for (int f = 0; f < F; f++) begin
          e = '0;
          e.sys = 1'b1;
          e.ena = (f < kk);
          e.enb = (f < kk);
          e.bub = (f >= kk);
          e.bb  = (f == 0);
          e.be  = (f == F - 1);
          e.aa  = 16'(a0 + rb * kk + f);
          e.ab  = 16'(b0 + cb * kk + f);
          exp_q.push_back(e);
        end
        for (int d = 0; d < DRAIN; d++) begin
          e = '0; e.sys = 1'b1; exp_q.push_back(e);
        end
        V = (mm - rb * T < T) ? (mm - rb * T) : T;
        for (int r = 0; r < V; r++) begin
          e = '0;
          e.enp = 1'b1;
          e.wep = 1'b1;
          e.rs  = 3'(r);
          e.ap  = 16'(p0 + (rb * T + r) * C + cb);
          exp_q.push_back(e);
        end
      end
    end
    e = '0; e.valid = 1'b1; exp_q.push_back(e);
    e = '0; exp_q.push_back(e);
  endfunction

  // Stream position: frozen by stall, saturates at the final idle entry.
  always @(posedge clk) begin
    if (!chk_en) pos <= 0;
    else if (!stall && pos < exp_q.size() - 1) pos <= pos + 1;
  end

  // Compare process: every cycle of a run, DUT outputs vs the model stream.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_e = exp_q[pos];
      if (stall) begin
        cmp_e.ena = 1'b0; cmp_e.enb = 1'b0; cmp_e.enp = 1'b0;
        cmp_e.wep = 1'b0; cmp_e.sys = 1'b0;
      end
      check($sformatf("cycle_pos%0d", pos), 64'(dut_e), 64'(cmp_e));
    end
  end

  task automatic launch(input int mm, input int kk, input int nn,
                        input int a0, input int b0, input int p0);
    build(mm, kk, nn, a0, b0, p0);
    @(posedge clk); #2;
    m = 16'(mm); k = 16'(kk); n = 16'(nn);
    ba = 16'(a0); bb = 16'(b0); bp = 16'(p0);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    // Scramble inputs: the run must only use the latched copies.
    m = 16'($urandom); k = 16'($urandom); n = 16'($urandom);
    ba = 16'($urandom); bb = 16'($urandom); bp = 16'($urandom);
    chk_en = 1'b1;
  endtask

  task automatic run_case(input int mm, input int kk, input int nn,
                          input int a0, input int b0, input int p0,
                          input int stall_at, input int stall_len, output int vcyc);
    int cyc, rem;
    bit stalled;
    nbub = 0; nena = 0; wq.delete();
    launch(mm, kk, nn, a0, b0, p0);
    cyc = 0; vcyc = -1; rem = 0; stalled = 1'b0;
    while (cyc < 3000 && !(pos == exp_q.size() - 1 && vcyc >= 0)) begin
      if (stall) begin
        rem--;
        if (rem == 0) stall = 1'b0;
      end else if (!stalled && stall_at >= 0 && pos == stall_at) begin
        stall = 1'b1; stalled = 1'b1; rem = stall_len;
      end
      @(negedge clk);
      if (valid_o && vcyc < 0) vcyc = cyc;
      if (bubble_o) nbub++;
      if (ena_o) nena++;
      if (enp_o) wq.push_back(addrp_o);
      @(posedge clk); #2;
      cyc++;
    end
    if (cyc >= 3000) check("run_timeout", 64'(cyc), 64'd0);
    @(negedge clk);
    chk_en = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  v;
    bit  saw;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", 64'(dut_e), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk) check("idle_outputs", 64'(dut_e), 64'd0);

    // 8x8x8 single tile
    run_case(8, 8, 8, 'h000, 'h100, 'h200, -1, 0, v);
    check("t1_valid_cycle", 64'(v), 64'd33);
    check("t1_writes", 64'(wq.size()), 64'd8);
    check("t1_first_addrp", 64'(wq[0]), 64'h200);
    check("t1_last_addrp", 64'(wq[7]), 64'h207);

    // k < TILE: bubble padding
    run_case(8, 3, 8, 'h010, 'h020, 'h030, -1, 0, v);
    check("t2_bubbles", 64'(nbub), 64'd5);
    check("t2_reads", 64'(nena), 64'd3);
    check("t2_valid_cycle", 64'(v), 64'd33);

    // 2x2 tiles, partial last row batch
    run_case(12, 8, 16, 'h000, 'h100, 'h300, -1, 0, v);
    check("t3_writes", 64'(wq.size()), 64'd24);
    check("t3_t11_row0", 64'(wq[20]), 64'h311);
    check("t3_t11_row1", 64'(wq[21]), 64'h313);
    check("t3_t11_row2", 64'(wq[22]), 64'h315);
    check("t3_t11_row3", 64'(wq[23]), 64'h317);
    check("t3_valid_cycle", 64'(v), 64'd121);

    // Stall 3 cycles when f=4 is presented
    run_case(8, 8, 8, 'h000, 'h100, 'h200, 5, 3, v);
    check("t4_stall_valid_cycle", 64'(v), 64'd36);
    check("t4_writes", 64'(wq.size()), 64'd8);

    // k > TILE, n < TILE, address wrap-around
    run_case(5, 10, 3, 'hFFFE, 'hFFF0, 'hFFFC, -1, 0, v);
    check("t5_writes", 64'(wq.size()), 64'd5);
    check("t5_wrap_addrp", 64'(wq[4]), 64'h0000);
    check("t5_reads", 64'(nena), 64'd10);
    check("t5_valid_cycle", 64'(v), 64'd32);

    // m = 0 pulse: straight to DONE
    run_case(0, 5, 5, 'h0, 'h0, 'h0, -1, 0, v);
    check("t6_zero_valid_cycle", 64'(v), 64'd1);
    check("t6_zero_access", 64'(nena + wq.size()), 64'd0);

    // k = 0 with start held: DONE persists, no buffer access
    @(posedge clk); #2;
    m = 16'd8; k = 16'd0; n = 16'd8; start = 1'b1;
    @(posedge clk); #2;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ena_o || enb_o || enp_o) saw = 1'b1;
      if (i == 1) check("k0_done_next", 64'(valid_o), 64'd1);
      @(posedge clk); #2;
    end
    @(negedge clk) check("k0_hold_done", 64'(valid_o), 64'd1);
    check("k0_no_access", 64'(saw), 64'd0);
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) check("k0_back_idle", 64'(valid_o), 64'd0);

    // Reset during WRITE
    launch(8, 8, 8, 'h000, 'h100, 'h200);
    for (int c = 0; c < 200 && pos != 28; c++) begin
      @(posedge clk); #2;
    end
    check("abort_reached_write", 64'(pos), 64'd28);
    check("abort_enp_before", 64'(enp_o), 64'd1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1 check("abort_outputs_zero", 64'(dut_e), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) check("abort_stays_idle", 64'(dut_e), 64'd0);
    end

    // Fresh run after the abort
    run_case(8, 8, 8, 'h000, 'h100, 'h200, -1, 0, v);
    check("rerun_valid_cycle", 64'(v), 64'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mm_tile_ctrl.md
Name: mm_tile_ctrl

Overview:
Parametrised tile-sequencing controller for the matrix-multiply accelerator; successor to the fixed 8x8 controller.
- Walks the output matrix in TILE x TILE tiles, row-batch major.
- Streams A/B operands from the global buffers into the systolic array, waits for the array to drain, then writes back only the valid result rows to buffer P.
- Adds operand latching, stall support, partial-tile writeback and zero-dimension handling.

Parameters:
ADDR_WIDTH, 16, width of dimensions and buffer addresses
TILE, 8, systolic array edge; power of two, 2..64
DRAIN_CYCLES, 16, cycles between last feed cycle and first result word valid (default 2*TILE)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
start_i  in  1  level start request; sampled in IDLE
stall_i  in  1  freeze all counters, state and enables this cycle
valid_o  out  1  high in DONE
m_i, k_i, n_i  in  ADDR_WIDTH each  dimensions (A is m x k, B is k x n); latched at start
base_addra_i, base_addrb_i, base_addrp_i  in  ADDR_WIDTH each  base addresses; latched at start
batch_begin_o  out  1  first FEED cycle of a tile
batch_end_o  out  1  last FEED cycle of a tile
ensys_o  out  1  systolic array shift enable (FEED or DRAIN, and not stalled)
bubble_o  out  1  FEED cycle index >= k; array inputs zeroed
ena_o / enb_o  out  1 each  A/B read enable
addra_o / addrb_o  out  ADDR_WIDTH each  A/B read addresses
enp_o / wep_o  out  1 each  P enable and write-enable, equal
addrp_o  out  ADDR_WIDTH  P write address
row_sel_o  out  log2(TILE)  array output row being written

Behaviour:
Reset:
- State IDLE; all counters and address registers 0; every output 0.
- Reset mid-operation aborts immediately with no further buffer access.

Latching:
- In IDLE with start_i=1, latch all dimensions and bases.
- The rest of the run uses only the latched copies; input changes mid-run are ignored.

Derived values:
- R = ceil(m/TILE), C = ceil(n/TILE), F = max(k, TILE).

States:
- IDLE -> DONE when start_i and any dimension is 0. This path makes no buffer access.
- IDLE -> FEED when start_i and all dimensions are nonzero.
- FEED: lasts F cycles, cycle counter f = 0..F-1.
  - ena_o = enb_o = (f < k).
  - addra_o = base_a + rb*k + f; addrb_o = base_b + cb*k + f.
  - Addresses are registered with their enables (same cycle).
  - bubble_o = (f >= k). batch_begin_o = (f == 0). batch_end_o = (f == F-1).
  - FEED -> DRAIN after f = F-1.
- DRAIN: DRAIN_CYCLES cycles, ensys_o=1, no buffer access; then -> WRITE.
- WRITE: V cycles, V = min(TILE, m - rb*TILE), row counter r = 0..V-1.
  - enp_o = wep_o = 1; row_sel_o = r.
  - addrp_o = base_p + (rb*TILE + r)*C + cb.
  - P is one word per TILE-wide output row segment.
- After WRITE: advance cb. If cb wraps from C-1 to 0, advance rb.
  - If rb == R-1 and cb == C-1 -> DONE; else -> FEED for the next tile.
- DONE: valid_o=1; -> IDLE when start_i=0. With start_i held high, stay in DONE (no restart).

Stall:
- While stall_i=1, hold state, counters and addresses.
- Force ena_o, enb_o, enp_o, wep_o, ensys_o to 0.
- Resume the exact same cycle when stall_i drops.

Arithmetic:
- All address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- The ceil computations must not overflow at m or n = 2^ADDR_WIDTH-1 (use ADDR_WIDTH+1-bit intermediates).

Boundaries:
- k < TILE: bubble cycles pad FEED to TILE.
- k = TILE: no bubbles.
- m not a multiple of TILE: last row batch writes only the valid rows.
- n not a multiple of TILE: full words are still written.

Test Plan:
- TILE=8, m=k=n=8, bases A=0x000, B=0x100, P=0x200, start pulse:
  - FEED 8 cycles with addra 0..7, addrb 0x100..0x107, no bubbles.
  - DRAIN 16 cycles.
  - WRITE 8 cycles with addrp 0x200..0x207.
  - valid_o rises exactly 33 cycles after the start-sample edge.
- m=8, k=3, n=8: bubble_o high for f=3..7; ena_o/enb_o high only for f=0..2; batch_end_o at f=7.
- m=12, k=8, n=16 (R=2, C=2):
  - Tile order (0,0), (0,1), (1,0), (1,1).
  - Tile (1,1) writes 4 rows at P-base offsets 17, 19, 21, 23.
  - valid_o after the 4th tile.
- k=0 with start: DONE next cycle; no ena_o/enb_o/enp_o pulses; hold start 5 cycles -> stays DONE; drop start -> IDLE.
- stall_i held 3 cycles mid-FEED at f=4: enables 0 and addresses frozen; on release f=4 is re-issued; total run length grows by exactly 3 cycles.
- Assert rst_ni low during WRITE: all outputs 0 immediately; after release, stays IDLE until a new start.
